btn_req_capture4: RTL and testbench
===================================

Name: btn_req_capture4

Overview:
- Front-end stage that drives the 4-input priority encoder's request lines a0..a3 from four raw, asynchronous push-button or request inputs.
- Each input is synchronised, debounced, and converted from a press edge into a sticky pending request.
- A request is held until the downstream consumer acknowledges it by returning the 2-bit code the encoder produced for it.
- This turns level-sensitive, bouncy inputs into clean, one-press-one-request events for the encoder.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clock cycles a synchronised input must differ from its debounced state before that state flips. Legal range 1..65535.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  4  raw asynchronous inputs, active-high; bit i is the source for a<i>.
- ack  in  1  one-cycle pulse: consumer has taken the request identified by ack_y0/ack_y1.
- ack_y0  in  1  MSB of the acknowledged code; same encoding as the encoder's y0.
- ack_y1  in  1  LSB of the acknowledged code; same encoding as the encoder's y1.
- a0, a1, a2, a3  out  1 each  registered pending-request lines to the encoder; a3 has highest priority downstream.
- pending  out  1  registered OR of a0..a3.
- dup_press  out  1  one-cycle pulse: a new press arrived on a line whose request was already pending.

Behaviour:
- Reset (async assert, sync release): all sync flops, debounced states, counters, a0..a3, pending and dup_press go to 0.
- Synchroniser: 2-flop synchroniser per bit. s_i is the second-flop output.
- Debounce, per bit:
  - deb_i is the debounced state; cnt_i is its CNT_W-bit counter.
  - If s_i == deb_i: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CYCLES-1: deb_i <= s_i and cnt_i <= 0.
  - Else: cnt_i <= cnt_i + 1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation is rejected.
  - Release (1->0) is debounced identically.
- Edge detect:
  - rise_i = deb_i & ~deb_d_i, where deb_d_i is deb_i delayed one cycle.
  - Only rising edges create requests; a held button produces exactly one request.
- Ack decode: ack selects index idx = {ack_y0, ack_y1}, i.e. 3 -> a3, 2 -> a2, 1 -> a1, 0 -> a0.
- Pending update per bit, evaluated every edge:
  - If rise_i: a_i <= 1. Set wins over a same-cycle ack of the same index.
  - Else if ack and idx == i: a_i <= 0.
  - Otherwise: hold.
- dup_press <= 1 for one cycle when rise_i occurs while a_i is already 1, for any i.
  - Multiple simultaneous duplicates still give a single-cycle pulse.
  - In the set-wins collision case, dup_press is also asserted.
- Ack to a non-pending index: no effect on any line, no error.
- pending <= next-state OR of a0..a3, so it is registered and aligned with the a lines.
- Latency: if btn_in rises before clock edge E0 and stays high, deb_i rises at E(DEBOUNCE_CYCLES+1) and a_i rises at E(DEBOUNCE_CYCLES+2).
- Ack latency: ack sampled at edge E clears a_i at E, so a_i reads 0 in the next cycle.
- Simultaneous presses on several bits set several a lines in the same cycle. The encoder resolves priority; the consumer acks each line in turn.
- rst_n asserted mid-debounce or with requests pending: everything clears immediately. After release, an input still held high is debounced again from scratch and generates a new request.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then btn_in=4'b0000 for 20 cycles -> a0..a3=0, pending=0, dup_press never asserted.
- btn_in[2] held high from just before E0 -> a2 rises at E6 and stays high while the button is held or released. Ack with ack_y0=1, ack_y1=0 -> a2=0 next cycle, pending=0.
- btn_in[1] bounces (1 for 2 cycles, 0 for 1, 1 for 3, then 0) -> no request. Then held high 10 cycles -> exactly one a1 request.
- btn_in=4'b1001 rise together -> a3 and a0 set in the same cycle. Ack code 11 clears only a3. Ack code 00 clears a0.
- a1 pending; release button, then press again and hold -> dup_press pulses 1 cycle and a1 stays 1. Ack code 01 landing in the same cycle as a new rise_1 -> a1 remains 1.
- Press btn_in[3], assert rst_n=0 at the debounce count of 2 with btn still high -> all outputs 0 immediately. Release reset -> a3 set 6 edges later.

Source files
------------

// File: rtl/btn_req_capture4.sv
// btn_req_capture4
// ----------------
// Front end for a 4-input priority encoder. Each raw, asynchronous, bouncy
// button or request input is synchronised, debounced, and turned from a
// press edge into a sticky pending request line. The request stays up until
// the consumer acknowledges it by handing back the 2-bit code the encoder
// produced for that line.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset, synchronous release expected
//   btn_in     in   [3:0] raw active-high inputs; bit i feeds a<i>
//   ack        in   one-cycle pulse: request {ack_y0, ack_y1} has been taken
//   ack_y0     in   MSB of the acknowledged code
//   ack_y1     in   LSB of the acknowledged code
//   a0..a3     out  registered pending-request lines (a3 highest priority downstream)
//   pending    out  registered OR of a0..a3
//   dup_press  out  one-cycle pulse: a press arrived on an already-pending line
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synchronised input must disagree with its
//                    debounced state before that state flips (1..65535)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES

module btn_req_capture4 #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_in,
  input  logic       ack,
  input  logic       ack_y0,
  input  logic       ack_y1,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       pending,
  output logic       dup_press
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser per input bit.
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Debounced level, its one-cycle delayed copy, and per-bit counters.
  logic [3:0]       deb_q;
  logic [3:0]       deb_d;
  logic [3:0]       deb_dly_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Request lines and derived outputs.
  logic [3:0] a_q;
  logic [3:0] a_d;
  logic       pending_q;
  logic       pending_d;
  logic       dup_q;
  logic       dup_d;

  logic [3:0] rise;
  logic [1:0] ack_idx;
  logic [3:0] ack_hit;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the counter only runs while the synchronised input disagrees
  // with the debounced level, so any disagreement shorter than
  // DEBOUNCE_CYCLES consecutive cycles restarts it from zero. Press and
  // release are treated identically.
  // ---------------------------------------------------------------------------
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q     <= 4'b0000;
      deb_dly_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press detection and request bookkeeping
  // ---------------------------------------------------------------------------
  assign rise    = deb_q & ~deb_dly_q;
  assign ack_idx = {ack_y0, ack_y1};

  always_comb begin
    ack_hit = 4'b0000;
    if (ack) begin
      ack_hit[ack_idx] = 1'b1;
    end
  end

  // A press that lands in the same cycle as the ack for its own line wins:
  // the consumer acked the old request, the new press is a fresh one.
  always_comb begin
    a_d       = (a_q & ~ack_hit) | rise;
    pending_d = |a_d;
    dup_d     = |(rise & a_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= 4'b0000;
      pending_q <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      pending_q <= pending_d;
      dup_q     <= dup_d;
    end
  end

  assign a0        = a_q[0];
  assign a1        = a_q[1];
  assign a2        = a_q[2];
  assign a3        = a_q[3];
  assign pending   = pending_q;
  assign dup_press = dup_q;

endmodule

// File: tb/tb_btn_req_capture4.sv
// Bench for btn_req_capture4 with DEBOUNCE_CYCLES = 4. Expected output
// vectors {dup_press, pending, a3, a2, a1, a0} are queued with the cycle
// they are due in when stimulus is driven; a monitor on the falling edge
// pops and compares them.

module tb_btn_req_capture4;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic       ack;
  logic       ack_y0;
  logic       ack_y1;
  logic       a0, a1, a2, a3;
  logic       pending;
  logic       dup_press;

  btn_req_capture4 #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .ack      (ack),
    .ack_y0   (ack_y0),
    .ack_y1   (ack_y1),
    .a0       (a0),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .pending  (pending),
    .dup_press(dup_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Output vector bit positions: {dup, pending, a3, a2, a1, a0}
  localparam logic [5:0] V_IDLE = 6'b00_0000;
  localparam logic [5:0] V_A0   = 6'b01_0001;
  localparam logic [5:0] V_A1   = 6'b01_0010;
  localparam logic [5:0] V_A2   = 6'b01_0100;
  localparam logic [5:0] V_A3   = 6'b01_1000;
  localparam logic [5:0] V_A30  = 6'b01_1001;
  localparam logic [5:0] V_DUP1 = 6'b11_0010;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [5:0] outs();
    return {dup_press, pending, a3, a2, a1, a0};
  endfunction

  // Expect vector v after clock edge E<e>, where E0 is the next rising edge.
  task automatic push(input int e, input string tag, input logic [5:0] v);
    exp_t x;
    x.cyc = cyc + 1 + e;
    x.tag = tag;
    x.val = {26'd0, v};
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ack_pulse(input logic y0, input logic y1);
    ack    = 1'b1;
    ack_y0 = y0;
    ack_y1 = y1;
    step(1);
    ack    = 1'b0;
    ack_y0 = 1'b0;
    ack_y1 = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, {26'd0, outs()}, e.val);
    end
  end

  initial begin
    rst_n  = 1'b1;
    btn_in = 4'b0000;
    ack    = 1'b0;
    ack_y0 = 1'b0;
    ack_y1 = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    chk("reset", {26'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Idle: nothing ever rises, dup_press never pulses.
    for (int k = 0; k < 20; k++) push(k, "idle", V_IDLE);
    step(20);

    // Single press on bit 2: a2 rises at E6, held through release.
    btn_in = 4'b0100;
    push(5, "a2_pre", V_IDLE);
    push(6, "a2_set", V_A2);
    push(9, "a2_hold", V_A2);
    step(10);
    btn_in = 4'b0000;
    push(7, "a2_released", V_A2);
    step(8);
    push(0, "a2_ack", V_IDLE);
    ack_pulse(1'b1, 1'b0);
    push(3, "a2_cleared", V_IDLE);
    step(4);

    // Bounce on bit 1 shorter than the debounce window: rejected.
    for (int k = 0; k < 16; k++) push(k, "bounce", V_IDLE);
    btn_in = 4'b0010; step(2);
    btn_in = 4'b0000; step(1);
    btn_in = 4'b0010; step(3);
    btn_in = 4'b0000; step(10);

    // Solid press on bit 1: exactly one request.
    btn_in = 4'b0010;
    push(5, "a1_pre", V_IDLE);
    push(6, "a1_set", V_A1);
    push(9, "a1_hold", V_A1);
    step(10);
    btn_in = 4'b0000;
    push(7, "a1_released", V_A1);
    step(8);
    push(0, "a1_ack", V_IDLE);
    ack_pulse(1'b0, 1'b1);
    push(5, "a1_once", V_IDLE);
    step(6);

    // Bits 3 and 0 together; ack 11 clears a3 only, ack 00 clears a0.
    btn_in = 4'b1001;
    push(5, "a30_pre", V_IDLE);
    push(6, "a30_set", V_A30);
    step(8);
    push(0, "ack_11", V_A0);
    ack_pulse(1'b1, 1'b1);
    push(0, "ack_00", V_IDLE);
    ack_pulse(1'b0, 1'b0);
    btn_in = 4'b0000;
    push(7, "a30_released", V_IDLE);
    step(8);

    // Duplicate press on pending a1.
    btn_in = 4'b0010;
    push(6, "dup_first", V_A1);
    step(10);
    btn_in = 4'b0000;
    step(8);
    btn_in = 4'b0010;
    push(5, "dup_pre", V_A1);
    push(6, "dup_pulse", V_DUP1);
    push(7, "dup_end", V_A1);
    step(10);
    btn_in = 4'b0000;
    step(8);

    // New press collides with ack 01 at the same edge: set wins, dup pulses.
    btn_in = 4'b0010;
    push(6, "collide", V_DUP1);
    push(7, "collide_after", V_A1);
    step(6);
    ack = 1'b1; ack_y0 = 1'b0; ack_y1 = 1'b1;
    step(1);
    ack = 1'b0; ack_y1 = 1'b0;
    step(5);

    // Ack to a non-pending line has no effect; then clear a1.
    push(0, "ack_nonpend", V_A1);
    ack_pulse(1'b1, 1'b1);
    push(0, "a1_clear", V_IDLE);
    ack_pulse(1'b0, 1'b1);
    btn_in = 4'b0000;
    step(8);

    // Leave a0 pending, then reset mid-debounce of bit 3.
    btn_in = 4'b0001;
    push(6, "a0_pend", V_A0);
    step(8);
    btn_in = 4'b0000;
    step(8);
    btn_in = 4'b1000;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {26'd0, outs()}, 32'd0);
    step(2);
    chk("rst_held", {26'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    push(5, "a3_pre", V_IDLE);
    push(6, "a3_after_rst", V_A3);
    step(8);

    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
    chk("sb_drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
